// File: rtl/hififo_request_split.sv
// hififo_request_split: turns one page request (start address + length, both in
// 8-byte words) into a sequence of PCIe read-request descriptors. Each descriptor
// is at most MAX_WORDS long and never crosses a 4 KB (512-word) boundary.
module hififo_request_split #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [60:0] in_addr,
  input  logic [18:0] in_count,
  output logic        in_ready,
  output logic        rq_valid,
  output logic [60:0] rq_addr,
  output logic [9:0]  rq_count,
  input  logic        rq_ready,
  output logic        done,
  output logic        err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [9:0] MAX_W  = 10'(MAX_WORDS);
  localparam logic [9:0] PAGE_W = 10'd512;

  state_t      state_q, state_d;
  logic [60:0] addr_q, addr_d;
  logic [18:0] rem_q, rem_d;
  logic        in_ready_q, in_ready_d;
  logic        rq_valid_q, rq_valid_d;
  logic [60:0] rq_addr_q, rq_addr_d;
  logic [9:0]  rq_count_q, rq_count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [9:0]  to_boundary;
  logic [9:0]  cap;
  logic [9:0]  chunk;
  logic [18:0] rem_after;
  logic        issue_hs;
  logic        issue_last;

  // Next descriptor length: min(remaining, MAX_WORDS, words left in the 4 KB page).
  // cap never exceeds 512, so the final selection fits in 10 bits.
  always_comb begin
    to_boundary = PAGE_W - {1'b0, addr_q[8:0]};
    cap         = (MAX_W < to_boundary) ? MAX_W : to_boundary;
    chunk       = (rem_q < {9'd0, cap}) ? rem_q[9:0] : cap;
  end

  // Descriptor handshake and whether it retires the request.
  always_comb begin
    issue_hs   = (state_q == S_ISSUE) && rq_ready;
    rem_after  = rem_q - {9'd0, rq_count_q};
    issue_last = (rem_after == '0);
  end

  // Next-state and next-output logic for the request splitter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rq_valid_d = rq_valid_q;
    rq_addr_d  = rq_addr_q;
    rq_count_d = rq_count_q;
    done_d     = 1'b0;
    err_d      = err_q | (in_valid && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d = in_addr;
          rem_d  = in_count;
          if (in_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rq_addr_d  = addr_q;
        rq_count_d = chunk;
        rq_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (rq_ready) begin
          addr_d     = addr_q + {51'd0, rq_count_q};
          rem_d      = rem_after;
          rq_valid_d = 1'b0;
          state_d    = issue_last ? S_IDLE : S_CALC;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rq_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; async reset drops any transfer in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b1;
      rq_valid_q <= 1'b0;
      rq_addr_q  <= '0;
      rq_count_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      in_ready_q <= in_ready_d;
      rq_valid_q <= rq_valid_d;
      rq_addr_q  <= rq_addr_d;
      rq_count_q <= rq_count_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // done: registered pulse for zero-length requests, same-cycle on the final handshake.
  always_comb begin
    in_ready    = in_ready_q;
    rq_valid    = rq_valid_q;
    rq_addr     = rq_addr_q;
    rq_count    = rq_count_q;
    done        = done_q | (issue_hs && issue_last);
    err_overrun = err_q;
  end

`ifndef SYNTHESIS
  // A stalled descriptor must stay put until it is taken.
  a_stable_when_stalled: assert property (
    @(posedge clock) disable iff (!reset_n)
      (rq_valid && !rq_ready) |=> (rq_valid && $stable(rq_addr) && $stable(rq_count))
  );

  // Descriptor length stays within 1..MAX_WORDS.
  a_count_range: assert property (
    @(posedge clock) disable iff (!reset_n)
      rq_valid |-> ((rq_count != '0) && (rq_count <= MAX_W))
  );

  // A descriptor never runs past the end of its 4 KB page.
  a_no_page_cross: assert property (
    @(posedge clock) disable iff (!reset_n)
      rq_valid |-> (({2'b00, rq_addr[8:0]} + {1'b0, rq_count}) <= 11'd512)
  );
`endif

endmodule

// File: tb/tb_hififo_request_split.sv
// Bench for hififo_request_split: table of requests plus hand-written corner
// sequences; expected descriptors are queued by a reference chunker when a
// request is driven and popped on each observed handshake.
module tb_hififo_request_split;

  localparam int unsigned MAXW = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [60:0] in_addr;
  logic [18:0] in_count;
  logic        in_ready;
  logic        rq_valid;
  logic [60:0] rq_addr;
  logic [9:0]  rq_count;
  logic        rq_ready;
  logic        done;
  logic        err_overrun;

  hififo_request_split #(.MAX_WORDS(MAXW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_addr     (in_addr),
    .in_count    (in_count),
    .in_ready    (in_ready),
    .rq_valid    (rq_valid),
    .rq_addr     (rq_addr),
    .rq_count    (rq_count),
    .rq_ready    (rq_ready),
    .done        (done),
    .err_overrun (err_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [60:0] addr;
    logic [9:0]  count;
    logic        last;
  } desc_t;

  typedef struct {
    logic [60:0] addr;
    logic [18:0] count;
    int unsigned stall;
    int unsigned exp_n;
  } req_vec_t;

  localparam int NV = 11;

  desc_t       exp_q[$];
  req_vec_t    vecs[NV];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        exp_err = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [60:0] prev_addr = '0;
  logic [9:0]  prev_count = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference chunker: queue every descriptor a request should produce.
  function automatic void model_push(input logic [60:0] a, input logic [18:0] c);
    logic [60:0] ad;
    int unsigned rem, room, ch;
    ad  = a;
    rem = c;
    while (rem != 0) begin
      room = 512 - int'(ad[8:0]);
      ch   = rem;
      if (ch > MAXW) ch = MAXW;
      if (ch > room) ch = room;
      exp_q.push_back('{ad, 10'(ch), (rem == ch)});
      ad  = ad + 61'(ch);
      rem = rem - ch;
    end
  endfunction

  // One cycle: drive on the falling edge, sample 1 ns later, score handshakes.
  task automatic step(input logic iv, input logic [60:0] a, input logic [18:0] c, input logic rdy);
    desc_t d;
    @(negedge clock);
    in_valid = iv;
    in_addr  = a;
    in_count = c;
    rq_ready = rdy;
    #1;
    cyc++;
    if (prev_valid && !prev_ready) begin
      check("stall_valid", 64'(rq_valid), 64'(1));
      check("stall_addr", 64'(rq_addr), 64'(prev_addr));
      check("stall_count", 64'(rq_count), 64'(prev_count));
    end
    if (rq_valid && !prev_valid)
      check("issue_latency", 64'(cyc - ref_cyc), 64'(2));
    if (rq_valid && rdy) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        check("rq_addr", 64'(rq_addr), 64'(d.addr));
        check("rq_count", 64'(rq_count), 64'(d.count));
        check("done_on_hs", 64'(done), 64'(d.last));
      end
      hs_cnt++;
      ref_cyc = cyc;
    end
    if (done) done_cnt++;
    prev_valid = rq_valid;
    prev_ready = rdy;
    prev_addr  = rq_addr;
    prev_count = rq_count;
  endtask

  // Run until the scoreboard drains and done has pulsed, then check totals.
  task automatic drain(input int d0, input int h0, input int unsigned exp_n, input int unsigned stall);
    int unsigned stall_left;
    logic r;
    stall_left = stall;
    for (int k = 0; k < 4000 && !(exp_q.size() == 0 && done_cnt != d0); k++) begin
      r = !(rq_valid && stall_left > 0);
      if (!r) stall_left--;
      step(1'b0, '0, '0, r);
    end
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    check("done_count", 64'(done_cnt - d0), 64'(1));
    check("ndesc", 64'(hs_cnt - h0), 64'(exp_n));
    step(1'b0, '0, '0, 1'b0);
    check("in_ready_back", 64'(in_ready), 64'(1));
    check("err_overrun", 64'(err_overrun), 64'(exp_err));
  endtask

  task automatic run_req(input logic [60:0] a, input logic [18:0] c,
                         input int unsigned stall, input int unsigned exp_n);
    int d0, h0;
    check("in_ready_idle", 64'(in_ready), 64'(1));
    d0 = done_cnt;
    h0 = hs_cnt;
    model_push(a, c);
    step(1'b1, a, c, 1'b0);
    ref_cyc = cyc;
    step(1'b0, '0, '0, 1'b0);
    check("in_ready_next", 64'(in_ready), 64'(c == '0));
    check("done_next", 64'(done), 64'(c == '0));
    drain(d0, h0, exp_n, stall);
  endtask

  initial begin
    int d0, h0;
    vecs[0]  = '{61'h0,                  19'd64,   0, 1};
    vecs[1]  = '{61'h1F0,                19'd40,   0, 2};
    vecs[2]  = '{61'h0,                  19'd200,  5, 4};
    vecs[3]  = '{61'h55,                 19'd0,    0, 0};
    vecs[4]  = '{61'h1FF,                19'd1,    0, 1};
    vecs[5]  = '{61'h1FF,                19'd3,    2, 2};
    vecs[6]  = '{61'h1C0,                19'd64,   0, 1};
    vecs[7]  = '{61'h1C1,                19'd64,   0, 2};
    vecs[8]  = '{61'h1FFFFFFFFFFFFFF0,   19'd32,   1, 2};
    vecs[9]  = '{61'h3,                  19'd1000, 1, 16};
    vecs[10] = '{61'h100,                19'd512,  3, 8};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_count = '0;
    rq_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_rq_valid", 64'(rq_valid), 64'(0));
    check("rst_rq_addr", 64'(rq_addr), 64'(0));
    check("rst_rq_count", 64'(rq_count), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err_overrun), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_req(vecs[i].addr, vecs[i].count, vecs[i].stall, vecs[i].exp_n);

    // Request arriving while a descriptor is pending is dropped and flagged.
    d0 = done_cnt;
    h0 = hs_cnt;
    model_push(61'h2000, 19'd100);
    step(1'b1, 61'h2000, 19'd100, 1'b0);
    ref_cyc = cyc;
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("ovr_valid", 64'(rq_valid), 64'(1));
    step(1'b1, 61'h777, 19'd9, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    exp_err = 1'b1;
    check("ovr_err", 64'(err_overrun), 64'(1));
    check("ovr_in_ready", 64'(in_ready), 64'(0));
    drain(d0, h0, 2, 0);

    // Async reset while a descriptor is pending clears everything at once.
    model_push(61'h1A0, 19'd200);
    step(1'b1, 61'h1A0, 19'd200, 1'b0);
    ref_cyc = cyc;
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("prerst_valid", 64'(rq_valid), 64'(1));
    check("prerst_addr", 64'(rq_addr), 64'(61'h1A0));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rq_valid", 64'(rq_valid), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_rq_addr", 64'(rq_addr), 64'(0));
    check("arst_rq_count", 64'(rq_count), 64'(0));
    check("arst_err", 64'(err_overrun), 64'(0));
    exp_q.delete();
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    exp_err    = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_req(61'h0, 19'd64, 0, 1);

    // in_valid coinciding with the final handshake still counts as overrun.
    d0 = done_cnt;
    h0 = hs_cnt;
    model_push(61'h40, 19'd8);
    step(1'b1, 61'h40, 19'd8, 1'b0);
    ref_cyc = cyc;
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("fin_valid", 64'(rq_valid), 64'(1));
    step(1'b1, 61'h999, 19'd5, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    exp_err = 1'b1;
    check("fin_err", 64'(err_overrun), 64'(1));
    check("fin_in_ready", 64'(in_ready), 64'(1));
    repeat (3) step(1'b0, '0, '0, 1'b1);
    check("fin_no_extra_valid", 64'(rq_valid), 64'(0));
    check("fin_ndesc", 64'(hs_cnt - h0), 64'(1));
    check("fin_done", 64'(done_cnt - d0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
